// File: rtl/pa_toeplitz_hash_ctrl.sv
// rtl/pa_toeplitz_hash_ctrl.sv - Bob-side privacy-amplification Toeplitz hash sequencer
// Preloads the datapath shift chain, runs key/random hashing beats, then hands off the hash.
module pa_toeplitz_hash_ctrl #(
  parameter int PA_W          = 64,
  parameter int PRELOAD_WORDS = 17,
  parameter int KEY_WORDS     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  input  logic [PA_W-1:0] rnd_data,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [PA_W-1:0] key_data,
  output logic            dp_shift_en,
  output logic            dp_key_en,
  output logic [PA_W-1:0] dp_random_bit,
  output logic [PA_W-1:0] dp_key_bit,
  output logic            hash_valid,
  input  logic            hash_ready,
  output logic            busy
);

  localparam int PCW = (PRELOAD_WORDS > 1) ? $clog2(PRELOAD_WORDS) : 1;
  localparam int KCW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [PCW-1:0] PRE_LAST = PCW'(PRELOAD_WORDS - 1);
  localparam logic [KCW-1:0] KEY_LAST = KCW'(KEY_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_HASH,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic [KCW-1:0] key_cnt_q, key_cnt_d;
  logic           beat;

  always_comb begin
    state_d       = state_q;
    pre_cnt_d     = pre_cnt_q;
    key_cnt_d     = key_cnt_q;
    beat          = 1'b0;
    rnd_ready     = 1'b0;
    key_ready     = 1'b0;
    dp_shift_en   = 1'b0;
    dp_key_en     = 1'b0;
    dp_random_bit = '0;
    dp_key_bit    = '0;
    hash_valid    = 1'b0;
    busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PRELOAD;
          pre_cnt_d = '0;
        end
      end

      S_PRELOAD: begin
        rnd_ready     = 1'b1;
        dp_shift_en   = rnd_valid;
        dp_random_bit = rnd_data;
        if (rnd_valid) begin
          if (pre_cnt_q == PRE_LAST) begin
            state_d   = S_HASH;
            pre_cnt_d = '0;
            key_cnt_d = '0;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
      end

      S_HASH: begin
        // Both streams advance together; a stall holds the sums via key_en=1, key_bit=0.
        beat          = rnd_valid & key_valid;
        rnd_ready     = beat;
        key_ready     = beat;
        dp_key_en     = 1'b1;
        dp_random_bit = rnd_data;
        dp_shift_en   = beat;
        dp_key_bit    = beat ? key_data : '0;
        if (beat) begin
          if (key_cnt_q == KEY_LAST) begin
            state_d   = S_DONE;
            key_cnt_d = '0;
          end else begin
            key_cnt_d = key_cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        hash_valid = 1'b1;
        dp_key_en  = 1'b1;
        if (hash_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything and completes no handshake in its cycle.
    if (abort) begin
      state_d     = S_IDLE;
      pre_cnt_d   = '0;
      key_cnt_d   = '0;
      rnd_ready   = 1'b0;
      key_ready   = 1'b0;
      dp_shift_en = 1'b0;
      dp_key_bit  = '0;
      hash_valid  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      key_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      key_cnt_q <= key_cnt_d;
    end
  end

endmodule

// File: tb/tb_pa_toeplitz_hash_ctrl.sv
// tb/tb_pa_toeplitz_hash_ctrl.sv - scoreboard bench for pa_toeplitz_hash_ctrl with a Toeplitz datapath model
module tb_pa_toeplitz_hash_ctrl;
  localparam int PA_W = 64;
  localparam int PRE  = 17;
  localparam int KW   = 16;

  logic            clk = 1'b0;
  logic            rst_n, start, abort, rnd_valid, key_valid, hash_ready;
  logic [PA_W-1:0] rnd_data, key_data, dp_random_bit, dp_key_bit;
  logic            rnd_ready, key_ready, dp_shift_en, dp_key_en, hash_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [PA_W-1:0] rnd_words [PRE+KW];
  logic [PA_W-1:0] key_words [KW];
  logic [PA_W-1:0] chain [PRE];
  logic [PA_W-1:0] hsum;
  logic [PA_W-1:0] sb_q [$];
  logic [PA_W-1:0] exp_hash;
  logic [PA_W-1:0] acc;

  always #5 clk = ~clk;

  pa_toeplitz_hash_ctrl #(.PA_W(PA_W), .PRELOAD_WORDS(PRE), .KEY_WORDS(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .dp_shift_en(dp_shift_en), .dp_key_en(dp_key_en),
    .dp_random_bit(dp_random_bit), .dp_key_bit(dp_key_bit),
    .hash_valid(hash_valid), .hash_ready(hash_ready), .busy(busy)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endfunction

  // Direct Toeplitz product: h[i] = XOR over key bits c of k[c] & r[c+i].
  function automatic logic [PA_W-1:0] golden();
    logic [PA_W-1:0] h;
    int b;
    h = '0;
    for (int c = 0; c < KW*PA_W; c++) begin
      if (key_words[c/PA_W][c%PA_W]) begin
        for (int i = 0; i < PA_W; i++) begin
          b = c + i;
          h[i] = h[i] ^ rnd_words[b/PA_W][b%PA_W];
        end
      end
    end
    return h;
  endfunction

  // Datapath model: shift chain of PRE words (index 0 oldest) and XOR accumulators.
  always @(posedge clk) begin
    acc = hsum;
    if (!dp_key_en) begin
      acc = '0;
    end else begin
      for (int j = 0; j < PA_W; j++) begin
        if (dp_key_bit[j]) begin
          for (int i = 0; i < PA_W; i++) acc[i] = acc[i] ^ chain[(j+i)/PA_W][(j+i)%PA_W];
        end
      end
    end
    hsum <= acc;
    if (dp_shift_en) begin
      for (int k = 0; k < PRE-1; k++) chain[k] <= chain[k+1];
      chain[PRE-1] <= dp_random_bit;
    end
  end

  // Monitor: every completed hash handshake pops one expected value.
  always @(negedge clk) begin
    #2;
    if (rst_n && hash_valid && hash_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hash_unexpected act=%h exp=none", hsum);
      end else begin
        exp_hash = sb_q.pop_front();
        chk("hash_product", hsum, exp_hash);
      end
    end
  end

  task automatic run_block(input bit stalls, input int bp, input int abort_at, input bit restart);
    int ri, ki, cyc, dcnt, ks, rs;
    bit fin, ab, bexp;
    logic [PA_W-1:0] held;
    ri = 0; ki = 0; cyc = 0; dcnt = 0; ks = 0; rs = 0; fin = 0; held = '0;
    @(negedge clk);
    start = 1'b1;
    if (abort_at < 0) sb_q.push_back(golden());
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 300) begin
      rnd_valid = 1'b1; key_valid = 1'b1; hash_ready = 1'b0;
      if (stalls && ri >= PRE && ki == 5 && ks < 3) begin key_valid = 1'b0; ks++; end
      if (stalls && ri >= PRE && ki == 10 && rs < 2) begin rnd_valid = 1'b0; rs++; end
      ab    = (ri >= PRE) && (ki == abort_at);
      abort = ab;
      start = restart && (ri >= PRE) && (ki == 3);
      rnd_data = rnd_words[(ri < PRE+KW) ? ri : 0];
      key_data = key_words[(ki < KW) ? ki : 0];
      if (ki >= KW) hash_ready = (dcnt >= bp);
      #1;
      chk("busy", busy, 1);
      if (ri < PRE) begin
        chk("pre_rnd_ready", rnd_ready, 1);
        chk("pre_key_ready", key_ready, 0);
        chk("pre_key_en", dp_key_en, 0);
        chk("pre_shift_en", dp_shift_en, rnd_valid);
        chk("pre_random_bit", dp_random_bit, rnd_data);
      end else if (ki < KW) begin
        bexp = rnd_valid && key_valid && !ab;
        chk("hash_rnd_ready", rnd_ready, bexp);
        chk("hash_key_ready", key_ready, bexp);
        chk("hash_key_en", dp_key_en, 1);
        chk("hash_shift_en", dp_shift_en, bexp);
        chk("hash_key_bit", dp_key_bit, bexp ? key_data : '0);
        chk("hash_valid_early", hash_valid, 0);
      end else begin
        chk("done_valid", hash_valid, 1);
        if (dcnt == 0) begin
          held = hsum;
          chk("done_latency", cyc, PRE + KW + (stalls ? 5 : 0));
        end else begin
          chk("bp_hold", hsum, held);
        end
        chk("done_key_en", dp_key_en, 1);
        chk("done_shift_en", dp_shift_en, 0);
        chk("done_rnd_ready", rnd_ready, 0);
        dcnt++;
      end
      if (ab) fin = 1;
      if (hash_valid && hash_ready) fin = 1;
      if (rnd_valid && rnd_ready) ri++;
      if (key_valid && key_ready) ki++;
      cyc++;
      @(negedge clk);
    end
    abort = 1'b0; hash_ready = 1'b0; start = 1'b0;
    chk("block_finished", fin, 1);
    #1;
    chk("after_busy", busy, 0);
    chk("after_key_en", dp_key_en, 0);
    chk("after_valid", hash_valid, 0);
    @(negedge clk);
    #1 chk("acc_cleared", hsum, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < PRE+KW; k++)
      rnd_words[k] = {32'hA5C3_0000 + 32'(k * 7919), 32'h1234_5678 ^ 32'(k * 32'h9E37_79B9)};
    for (int k = 0; k < KW; k++)
      key_words[k] = {32'h0F1E_2D3C ^ 32'(k * 32'h0101_0101), 32'hDEAD_0000 + 32'(k * 104729)};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hash_ready = 1'b1;
    rnd_valid = 1'b1; key_valid = 1'b1;
    rnd_data = rnd_words[0]; key_data = key_words[0];
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_shift_en", dp_shift_en, 0);
    chk("rst_key_en", dp_key_en, 0);
    chk("rst_random_bit", dp_random_bit, 0);
    chk("rst_key_bit", dp_key_bit, 0);
    chk("rst_hash_valid", hash_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rnd_valid = 1'b0; key_valid = 1'b0; hash_ready = 1'b0;

    run_block(1'b0, 0, -1, 1'b0);
    run_block(1'b1, 0, -1, 1'b0);
    run_block(1'b0, 10, -1, 1'b0);
    run_block(1'b0, 0, 7, 1'b0);
    run_block(1'b0, 0, -1, 1'b1);

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rnd_valid = 1'b1;
    rnd_data = rnd_words[0];
    repeat (4) @(negedge clk);
    #1 chk("midpre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rnd_ready", rnd_ready, 0);
    chk("arst_shift_en", dp_shift_en, 0);
    chk("arst_random_bit", dp_random_bit, 0);
    chk("arst_key_en", dp_key_en, 0);
    chk("arst_hash_valid", hash_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rnd_valid = 1'b0;

    run_block(1'b0, 0, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
